edge_delay_meter: RTL and testbench

- Measures, in clock cycles, the delay between each edge on a stimulus signal and the matching edge on a delayed response signal.
- Designed to sit beside a delay element (transport or inertial) and check pulse-by-pulse propagation, including several pulses in flight at once.
- Stimulus edges are timestamped into a small FIFO and matched in order against response edges.
- Reports each measured delay, plus sticky error flags for overflow, timeout and unmatched or mis-polarity edges.

---
 rtl/edge_delay_meter.sv | 147 ++++++++++++++
 tb/tb_edge_delay_meter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/edge_delay_meter.sv
// Edge-to-edge delay meter: timestamps stimulus edges into a small FIFO and
// matches them in order against response edges, reporting each delay in cycles.
module edge_delay_meter #(
  parameter int CNT_W   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     err_clr,
  input  logic                     stim_in,
  input  logic                     resp_in,
  output logic                     meas_valid,
  output logic [CNT_W-1:0]         meas_delay,
  output logic                     meas_rise,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     err_overflow,
  output logic                     err_timeout,
  output logic                     err_unmatched
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [CNT_W-1:0] ts;
    logic             pol;
  } entry_t;

  entry_t fifo_mem [DEPTH];

  logic             stim_q, stim_d;
  logic             resp_q, resp_d;
  logic [CNT_W-1:0] ts_q, ts_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             meas_valid_q, meas_valid_d;
  logic [CNT_W-1:0] meas_delay_q, meas_delay_d;
  logic             meas_rise_q, meas_rise_d;
  logic             err_overflow_q, err_overflow_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_unmatched_q, err_unmatched_d;

  logic             stim_edge, resp_edge, empty, full;
  logic             resp_pop, resp_direct, resp_orphan, timeout_pop;
  logic             pop, push_req, push, overflow, pol_bad;
  entry_t           head;
  logic [CNT_W-1:0] age;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    stim_d      = stim_in;
    resp_d      = resp_in;
    ts_d        = en ? ts_q + CNT_W'(1) : ts_q;

    stim_edge   = en && (stim_in != stim_q);
    resp_edge   = en && (resp_in != resp_q);
    empty       = (count_q == '0);
    full        = (count_q == CW'(DEPTH));
    head        = fifo_mem[rd_ptr_q];
    age         = ts_q - head.ts;

    // A response edge always takes priority over the timeout check.
    resp_pop    = resp_edge && !empty;
    resp_direct = resp_edge && empty && stim_edge;
    resp_orphan = resp_edge && empty && !stim_edge;
    timeout_pop = en && !empty && !resp_edge && (age == CNT_W'(TIMEOUT));

    pop         = resp_pop || timeout_pop;
    push_req    = stim_edge && !resp_direct;
    push        = push_req && (!full || pop);
    overflow    = push_req && full && !pop;
    pol_bad     = (resp_pop && (resp_in != head.pol)) ||
                  (resp_direct && (resp_in != stim_in));

    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);

    // The reported polarity is that of the stimulus edge being matched.
    meas_valid_d = resp_pop || resp_direct;
    meas_delay_d = meas_delay_q;
    meas_rise_d  = meas_rise_q;
    if (resp_pop) begin
      meas_delay_d = age;
      meas_rise_d  = head.pol;
    end else if (resp_direct) begin
      meas_delay_d = '0;
      meas_rise_d  = stim_in;
    end

    // A new error in the same cycle as err_clr leaves the flag set.
    err_overflow_d  = overflow || (err_overflow_q && !err_clr);
    err_timeout_d   = timeout_pop || (err_timeout_q && !err_clr);
    err_unmatched_d = resp_orphan || pol_bad || (err_unmatched_q && !err_clr);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    if (rst) begin
      stim_q          <= stim_in;
      resp_q          <= resp_in;
      ts_q            <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      meas_valid_q    <= 1'b0;
      meas_delay_q    <= '0;
      meas_rise_q     <= 1'b0;
      err_overflow_q  <= 1'b0;
      err_timeout_q   <= 1'b0;
      err_unmatched_q <= 1'b0;
    end else begin
      stim_q          <= stim_d;
      resp_q          <= resp_d;
      ts_q            <= ts_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      meas_valid_q    <= meas_valid_d;
      meas_delay_q    <= meas_delay_d;
      meas_rise_q     <= meas_rise_d;
      err_overflow_q  <= err_overflow_d;
      err_timeout_q   <= err_timeout_d;
      err_unmatched_q <= err_unmatched_d;
    end
  end

  // NOTE: the storage array has no reset; entry validity comes from count_q,
  // which keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && push) fifo_mem[wr_ptr_q] <= '{ts: ts_q, pol: stim_in};
  end

  assign meas_valid    = meas_valid_q;
  assign meas_delay    = meas_delay_q;
  assign meas_rise     = meas_rise_q;
  assign pending       = count_q;
  assign err_overflow  = err_overflow_q;
  assign err_timeout   = err_timeout_q;
  assign err_unmatched = err_unmatched_q;

endmodule

// File: tb/tb_edge_delay_meter.sv
// Scoreboard bench for edge_delay_meter: directed edge patterns push expected
// measurements; a negedge monitor pops and compares each meas_valid pulse.
module tb_edge_delay_meter;

  localparam int CNT_W = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst, en, err_clr, stim_in, resp_in;
  logic             meas_valid, meas_rise;
  logic [CNT_W-1:0] meas_delay;
  logic [2:0]       pending;
  logic             err_overflow, err_timeout, err_unmatched;

  typedef struct {
    int delay;
    int rise;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  edge_delay_meter #(.CNT_W(CNT_W), .DEPTH(DEPTH), .TIMEOUT(200)) dut (
    .clk(clk), .rst(rst), .en(en), .err_clr(err_clr),
    .stim_in(stim_in), .resp_in(resp_in),
    .meas_valid(meas_valid), .meas_delay(meas_delay), .meas_rise(meas_rise),
    .pending(pending), .err_overflow(err_overflow), .err_timeout(err_timeout),
    .err_unmatched(err_unmatched)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_meas(input int delay, input int rise);
    exp_t e;
    e.delay = delay;
    e.rise  = rise;
    sb.push_back(e);
  endtask

  // Inputs change 1 time unit after a rising edge and are sampled at the next.
  task automatic drive(input logic s, input logic r);
    stim_in = s;
    resp_in = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic s, input logic r);
    rst = 1'b1;
    drive(s, r);
    rst = 1'b0;
  endtask

  task automatic check_errs(input string tag, input int ov, input int to, input int um);
    check({tag, "_err_overflow"}, int'(err_overflow), ov);
    check({tag, "_err_timeout"}, int'(err_timeout), to);
    check({tag, "_err_unmatched"}, int'(err_unmatched), um);
  endtask

  function automatic logic pulse_at(input int i);
    return (i >= 0) && (i < 16) && ((i % 4) < 2);
  endfunction

  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_meas: got delay=%0d rise=%0d expected no pulse",
                 meas_delay, meas_rise);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("meas_delay", int'(meas_delay), e.delay);
        check("meas_rise", int'(meas_rise), e.rise);
      end
    end
  end

  initial begin
    int   peak;
    logic r_prev, r_cur;

    rst = 1'b1; en = 1'b1; err_clr = 1'b0; stim_in = 1'b0; resp_in = 1'b0;

    // 1. Reset state, then a single pulse echoed 3 cycles later.
    do_reset(1'b0, 1'b0);
    check("rst_meas_valid", int'(meas_valid), 0);
    check("rst_meas_delay", int'(meas_delay), 0);
    check("rst_pending", int'(pending), 0);
    check_errs("rst", 0, 0, 0);
    repeat (4) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    check("t1_pending_rise", int'(pending), 1);
    repeat (2) drive(1'b1, 1'b0);
    expect_meas(3, 1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b1);
    expect_meas(3, 0);
    drive(1'b0, 1'b0);
    check("t1_pending_end", int'(pending), 0);
    check_errs("t1", 0, 0, 0);

    // 2. Width-2 pulses every 4 cycles, response delayed 7: up to 4 in flight.
    peak   = 0;
    r_prev = 1'b0;
    for (int i = 0; i < 26; i++) begin
      r_cur = pulse_at(i - 7);
      if (r_cur != r_prev) expect_meas(7, int'(r_cur));
      r_prev = r_cur;
      drive(pulse_at(i), r_cur);
      if (int'(pending) > peak) peak = int'(pending);
    end
    check("t2_peak_pending", peak, 4);
    check("t2_pending_end", int'(pending), 0);
    check_errs("t2", 0, 0, 0);

    // 3. Five stimulus edges into a 4-deep FIFO with no response.
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    check("t3_pending_full", int'(pending), 4);
    check("t3_no_overflow_yet", int'(err_overflow), 0);
    drive(1'b1, 1'b0);
    check("t3_pending_after_drop", int'(pending), 4);
    check("t3_err_overflow", int'(err_overflow), 1);
    err_clr = 1'b1;
    drive(1'b1, 1'b0);
    err_clr = 1'b0;
    check("t3_cleared_overflow", int'(err_overflow), 0);
    check("t3_pending_kept", int'(pending), 4);

    // 4a. Edge at ts=250 ages out at ts=194 after the counter wraps.
    do_reset(1'b0, 1'b0);
    repeat (250) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    repeat (199) drive(1'b1, 1'b0);
    check("t4_pending_before_to", int'(pending), 1);
    check("t4_timeout_before", int'(err_timeout), 0);
    drive(1'b1, 1'b0);
    check("t4_pending_after_to", int'(pending), 0);
    check("t4_err_timeout", int'(err_timeout), 1);

    // 4b. Edge at ts=250, response at ts=4 (wrapped): delay 10.
    do_reset(1'b0, 1'b0);
    repeat (250) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    repeat (9) drive(1'b1, 1'b0);
    expect_meas(10, 1);
    drive(1'b1, 1'b1);
    check("t4b_pending", int'(pending), 0);
    check_errs("t4b", 0, 0, 0);

    // 5. Orphan response, err_clr, simultaneous edges, polarity mismatch.
    do_reset(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    check("t5_err_unmatched", int'(err_unmatched), 1);
    check("t5_pending_orphan", int'(pending), 0);
    err_clr = 1'b1;
    drive(1'b0, 1'b1);
    err_clr = 1'b0;
    check("t5_unmatched_cleared", int'(err_unmatched), 0);
    do_reset(1'b0, 1'b0);
    expect_meas(0, 1);
    drive(1'b1, 1'b1);
    check("t5_pending_simul", int'(pending), 0);
    check("t5_simul_unmatched", int'(err_unmatched), 0);
    do_reset(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    expect_meas(1, 0);
    drive(1'b0, 1'b1);
    check("t5_pol_unmatched", int'(err_unmatched), 1);
    check("t5_pol_pending", int'(pending), 0);

    // 6. en=0 ignores edges and holds state; reset drops pending edges.
    do_reset(1'b0, 1'b0);
    en = 1'b0;
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    check("t6_pending_en0", int'(pending), 0);
    check_errs("t6_en0", 0, 0, 0);
    en = 1'b1;
    drive(1'b1, 1'b1);
    check("t6_no_false_edge", int'(pending), 0);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    check("t6_pending3", int'(pending), 3);
    en = 1'b0;
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    check("t6_hold_pending", int'(pending), 3);
    check("t6_hold_unmatched", int'(err_unmatched), 0);
    en = 1'b1;
    do_reset(1'b0, 1'b1);
    check("t6_rst_pending", int'(pending), 0);
    check("t6_rst_meas_valid", int'(meas_valid), 0);
    check_errs("t6_rst", 0, 0, 0);
    repeat (6) drive(1'b0, 1'b1);
    check("t6_post_pending", int'(pending), 0);

    repeat (3) drive(stim_in, resp_in);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
